// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, controller
// stage encodings, the IF/ID register layout and PC helper functions.
package if_stage_pkg;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IF,
    ST_IF_WAIT,
    ST_ID,
    ST_EX,
    ST_MEM,
    ST_MEM_WAIT,
    ST_WB
  } stage_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

  // Redirect targets are always word-aligned; low bits are dropped, not trapped.
  function automatic logic [31:0] align_target(input logic [31:0] target);
    return {target[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle between the stage controller / EX-MEM / imem side and the fetch stage.
interface if_stage_if #(
  parameter int IMEM_ADDR_W = 14
);
  logic                   pc_wren;
  logic                   if_id_wren;
  logic                   stage_reset_n;
  logic                   branch_taken;
  logic [31:0]            branch_target;
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [31:0]            imem_rdata;
  logic [31:0]            if_id_inst;
  logic [31:0]            if_id_pc;
  logic [31:0]            if_id_pc4;
  logic                   if_id_valid;
  logic                   fetch_err;
  logic                   misalign_err;
  logic [63:0]            instret;

  modport master (
    output pc_wren, if_id_wren, stage_reset_n, branch_taken, branch_target, imem_rdata,
    input  imem_addr, if_id_inst, if_id_pc, if_id_pc4, if_id_valid,
           fetch_err, misalign_err, instret
  );

  modport slave (
    input  pc_wren, if_id_wren, stage_reset_n, branch_taken, branch_target, imem_rdata,
    output imem_addr, if_id_inst, if_id_pc, if_id_pc4, if_id_valid,
           fetch_err, misalign_err, instret
  );
endinterface

// File: rtl/if_stage_fetch_latency_tracker.sv
// Counts cycles since the last PC commit and flags when the instruction memory
// output reflects the current address.
module fetch_latency_tracker #(
  parameter int IMEM_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic data_ready
);

  localparam logic [2:0] LAT = 3'(IMEM_LATENCY);

  logic [2:0] r_lat_cnt;

  // Saturates at the latency so data_ready stays high until the next commit.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      r_lat_cnt <= 3'd0;
    end else if (r_lat_cnt != LAT) begin
      r_lat_cnt <= r_lat_cnt + 3'd1;
    end
  end

  assign data_ready = (r_lat_cnt == LAT);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem word address, and loads
// the IF/ID register under stage-controller control.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int          IMEM_ADDR_W  = 14,
  parameter int          IMEM_LATENCY = 1
) (
  input  logic     clk,
  input  logic     reset,
  if_stage_if.slave bus
);

  logic [31:0] r_pc;
  if_id_t      r_if_id;
  logic        r_fetch_err;
  logic        r_misalign_err;
  logic [63:0] r_instret;

  logic [31:0] w_next_pc;
  logic        w_misaligned;
  logic        w_data_ready;

  assign w_next_pc    = bus.branch_taken ? align_target(bus.branch_target) : pc_plus4(r_pc);
  assign w_misaligned = bus.branch_taken && (bus.branch_target[1:0] != 2'b00);

  fetch_latency_tracker #(
    .IMEM_LATENCY(IMEM_LATENCY)
  ) u_lat (
    .clk       (clk),
    .reset     (reset),
    .restart   (bus.pc_wren),
    .data_ready(w_data_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc           <= RESET_PC;
      r_instret      <= 64'd0;
      r_misalign_err <= 1'b0;
    end else if (bus.pc_wren) begin
      r_pc      <= w_next_pc;
      r_instret <= r_instret + 64'd1;
      if (w_misaligned) begin
        r_misalign_err <= 1'b1;
      end
    end
  end

  // IF/ID samples the pre-commit PC, so a same-cycle pc_wren never leaks in.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_id.inst  <= INST_NOP;
      r_if_id.pc    <= RESET_PC;
      r_if_id.pc4   <= pc_plus4(RESET_PC);
      r_if_id.valid <= 1'b0;
      r_fetch_err   <= 1'b0;
    end else if (!bus.stage_reset_n) begin
      r_if_id.inst  <= INST_NOP;
      r_if_id.valid <= 1'b0;
    end else if (bus.if_id_wren) begin
      r_if_id.inst  <= bus.imem_rdata;
      r_if_id.pc    <= r_pc;
      r_if_id.pc4   <= pc_plus4(r_pc);
      r_if_id.valid <= 1'b1;
      if (!w_data_ready) begin
        r_fetch_err <= 1'b1;
      end
    end
  end

  assign bus.imem_addr    = r_pc[IMEM_ADDR_W+1:2];
  assign bus.if_id_inst   = r_if_id.inst;
  assign bus.if_id_pc     = r_if_id.pc;
  assign bus.if_id_pc4    = r_if_id.pc4;
  assign bus.if_id_valid  = r_if_id.valid;
  assign bus.fetch_err    = r_fetch_err;
  assign bus.misalign_err = r_misalign_err;
  assign bus.instret      = r_instret;

endmodule
